// File: rtl/gf128_pkg.sv
// Shared constants for the GF(2^128) reduction path, modulo P(x) = x^128 + x^7 + x^2 + x + 1.
package gf128_pkg;

  localparam int GF128_W      = 128;
  localparam int GF128_PROD_W = 256;
  localparam int GF128_FOLD_W = 135;

  // Low-order terms of P(x): x^7 + x^2 + x + 1.
  localparam logic [7:0] GF128_POLY_LOW = 8'h87;

endpackage

// File: rtl/gf128_fold.sv
// Combinational fold term: src ^ (src<<1) ^ (src<<2) ^ (src<<7), zero-extended to SRC_W+7 bits.
module gf128_fold
  import gf128_pkg::*;
#(
  parameter int SRC_W = 128
) (
  input  logic [SRC_W-1:0] src,
  output logic [SRC_W+6:0] fold
);

  localparam int OUT_W = SRC_W + 7;

  logic [OUT_W-1:0] ext;

  assign ext = OUT_W'(src);

  // Each set bit k of the low polynomial contributes src shifted by k.
  always_comb begin
    fold = '0;
    for (int k = 0; k < 8; k++) begin
      if (GF128_POLY_LOW[k]) begin
        fold = fold ^ (ext << k);
      end
    end
  end

endmodule

// File: rtl/gf128_reduce_pipe.sv
// Two-stage pipelined reduction of a 256-bit carry-less product modulo P(x) to a 128-bit element.
// Optional sideband tag travelling with each product: define GF128_REDUCE_TAG_EN.
module gf128_reduce_pipe
  import gf128_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [GF128_PROD_W-1:0] in_product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [GF128_W-1:0]      out_result
`ifdef GF128_REDUCE_TAG_EN
  ,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [TAG_W-1:0]        out_tag
`endif
);

  localparam int OVF_W = GF128_FOLD_W - GF128_W;

  // Handshake: a transfer happens on a rising edge where valid && ready; a producer holding
  // valid keeps its data stable until that edge, and ready may depend on the downstream ready.
  logic                    s1_valid;
  logic [GF128_FOLD_W-1:0] s1_data;
  logic                    s2_valid;
  logic [GF128_W-1:0]      s2_data;
  logic                    s1_en;
  logic                    s2_en;

  logic [GF128_FOLD_W-1:0] fold_hi;
  logic [OVF_W+6:0]        fold_ovf;
  logic [GF128_FOLD_W-1:0] t_next;
  logic [GF128_W-1:0]      r_next;

  gf128_fold #(.SRC_W(GF128_W)) u_fold_hi (
    .src  (in_product[GF128_PROD_W-1:GF128_W]),
    .fold (fold_hi)
  );

  gf128_fold #(.SRC_W(OVF_W)) u_fold_ovf (
    .src  (s1_data[GF128_FOLD_W-1:GF128_W]),
    .fold (fold_ovf)
  );

  assign t_next = GF128_FOLD_W'(in_product[GF128_W-1:0]) ^ fold_hi;
  // The overflow fold reaches only bit 13, so one more XOR finishes the reduction.
  assign r_next = s1_data[GF128_W-1:0] ^ GF128_W'(fold_ovf);

  assign s2_en    = !s2_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  assign out_valid  = s2_valid;
  assign out_result = s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= t_next;
        end
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= r_next;
        end
      end
    end
  end

`ifdef GF128_REDUCE_TAG_EN
  logic [TAG_W-1:0] s1_tag;
  logic [TAG_W-1:0] s2_tag;

  assign out_tag = s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tag <= '0;
      s2_tag <= '0;
    end else begin
      if (s1_en && in_valid) begin
        s1_tag <= in_tag;
      end
      if (s2_en && s1_valid) begin
        s2_tag <= s1_tag;
      end
    end
  end
`endif

endmodule
